// File: rtl/mac_pkg.sv
// Shared MAC definitions: bf16 result type, FP8 format constants and the
// lane-insert helper used by the result packer.
package mac_pkg;
  localparam int BF16_W = 16;
  typedef logic [BF16_W-1:0] bf16_t;

  localparam int FP8_W         = 8;
  localparam int FP8_E4M3_BIAS = 7;
  localparam int FP8_E5M2_BIAS = 15;

  // Widest packed word the helper handles; callers zero-extend and truncate.
  localparam int PACK_MAX_LANES = 32;
  localparam int PACK_MAX_W     = PACK_MAX_LANES * BF16_W;
  typedef logic [PACK_MAX_W-1:0] pack_word_t;

  function automatic pack_word_t pack_lane(pack_word_t word, int unsigned idx, bf16_t val);
    pack_word_t w;
    w = word;
    w[idx*BF16_W +: BF16_W] = val;
    return w;
  endfunction
endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible as soon as the
// pointers show it non-empty. Pointers carry one extra wrap bit.
module mac_result_fifo #(
  parameter int FW    = 137,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [FW-1:0] wdata_i,
  input  logic          rd_en_i,
  output logic [FW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  logic [FW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          do_wr, do_rd;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign do_rd   = rd_en_i & ~empty_o;
  // A pop on the same edge frees the slot the push lands in.
  assign do_wr   = wr_en_i & (~full_o | do_rd);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_wr) wr_q <= wr_q + (AW+1)'(1);
      if (do_rd) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mac_result_packer.sv
// Packs LANES bf16 MAC results into one wide word, buffers words in a small
// FWFT FIFO and presents them on valid/ready; sticky overflow flags drops.
module mac_result_packer
  import mac_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 4,
  parameter int DW    = BF16_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            din,
  input  logic                     din_valid,
  input  logic                     flush,
  output logic [LANES*DW-1:0]      dout,
  output logic [LANES-1:0]         dout_keep,
  output logic                     dout_last,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int LW = $clog2(LANES);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = LANES * DW;
  localparam int FW = W + LANES + 1;

  logic [LW-1:0]    lane_q;
  logic [W-1:0]     pack_q, pack_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic             overflow_q;
  pack_word_t       ext;
  logic             close_full, close_flush, push, pop;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_rdata;

  // Next pack contents including any same-cycle din.
  always_comb begin
    ext = '0;
    ext[W-1:0] = pack_q;
    if (din_valid) ext = pack_lane(ext, 32'(lane_q), bf16_t'(din));
    pack_d = ext[W-1:0];
    keep_d = keep_q;
    if (din_valid) keep_d[lane_q] = 1'b1;
  end

  generate
    if (W < PACK_MAX_W) begin : g_ext_hi
      logic unused_ext_hi;
      assign unused_ext_hi = ^ext[PACK_MAX_W-1:W];
    end
  endgenerate

  assign close_full  = din_valid && (lane_q == LW'(LANES-1));
  assign close_flush = flush && (|keep_d);
  assign push        = close_full | close_flush;
  assign pop         = dout_valid & dout_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q     <= '0;
      pack_q     <= '0;
      keep_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        lane_q <= '0;
        pack_q <= '0;
        keep_q <= '0;
      end else if (din_valid) begin
        lane_q <= lane_q + LW'(1);
        pack_q <= pack_d;
        keep_q <= keep_d;
      end
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  mac_result_fifo #(.FW(FW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (push),
    .wdata_i ({close_flush, keep_d, pack_d}),
    .rd_en_i (dout_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign {dout_last, dout_keep, dout} = fifo_rdata;
  assign dout_valid = ~fifo_empty;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_mac_result_packer.sv
// Scoreboard bench for mac_result_packer: tasks queue expected words, a
// monitor pops and compares on every handshake.
module tb_mac_result_packer;
  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int W     = LANES * DW;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [LANES-1:0] keep;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    din = '0;
  logic             din_valid = 1'b0;
  logic             flush = 1'b0;
  logic [W-1:0]     dout;
  logic [LANES-1:0] dout_keep;
  logic             dout_last;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [2:0]       level;
  logic             overflow;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  mac_result_packer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .flush(flush),
    .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mkw(input logic [15:0] base, input int n, input bit last);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    for (int i = 0; i < n; i++) begin
      e.data[i*DW +: DW] = base + 16'(i);
      e.keep[i] = 1'b1;
    end
    e.last = last;
    return e;
  endfunction

  // Monitor: compare each popped word and check stability while stalled.
  initial begin
    exp_t e;
    exp_t held;
    bit   stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(posedge clk);
      if (rst_n && stall && dout_valid) begin
        n_chk++;
        if ({dout, dout_keep, dout_last} !== held)
          $display("FAIL hold_stable got %h exp %h", {dout, dout_keep, dout_last}, held);
        else n_pass++;
      end
      if (rst_n && dout_valid && dout_ready) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL pop_unexpected got data=%h keep=%h", dout, dout_keep);
        else begin
          e = q.pop_front();
          if ({dout, dout_keep, dout_last} !== e)
            $display("FAIL pop_word got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                     dout, dout_keep, dout_last, e.data, e.keep, e.last);
          else n_pass++;
        end
      end
      stall = rst_n && dout_valid && !dout_ready;
      held  = {dout, dout_keep, dout_last};
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input bit f);
    din_valid = v; din = d; flush = f;
    @(negedge clk);
    din_valid = 1'b0; din = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b1; din = 16'hDEAD; flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; din_valid = 1'b0; din = '0; flush = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({dout_valid, level, overflow, dout_last, dout_keep} !== '0 || dout !== '0)
      $display("FAIL reset_state got valid=%b level=%0d ovf=%b keep=%h dout=%h exp all zero",
               dout_valid, level, overflow, dout_keep, dout);
    else n_pass++;
  endtask

  task automatic test_full_word();
    exp_t e;
    dout_ready = 1'b1;
    e = mkw(16'h0001, 8, 1'b0);
    q.push_back(e);
    for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b0);
    n_chk++;
    if (!dout_valid || level !== 3'd1 || dout !== 128'h0008_0007_0006_0005_0004_0003_0002_0001 ||
        dout_keep !== 8'hFF || dout_last !== 1'b0)
      $display("FAIL full_word got valid=%b level=%0d dout=%h keep=%h last=%b",
               dout_valid, level, dout, dout_keep, dout_last);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
    n_chk++;
    if (level !== 3'd0 || dout_valid !== 1'b0) $display("FAIL full_word_drain got level=%0d exp 0", level);
    else n_pass++;
  endtask

  task automatic test_flush_partial();
    exp_t e;
    e.data = {80'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    e.keep = 8'h07;
    e.last = 1'b1;
    q.push_back(e);
    drive(1'b1, 16'hAAAA, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 16'hBBBB, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 16'hCCCC, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (!dout_valid || dout !== e.data || dout_keep !== 8'h07 || dout_last !== 1'b1)
      $display("FAIL flush_partial got valid=%b dout=%h keep=%h last=%b exp keep=07 last=1",
               dout_valid, dout, dout_keep, dout_last);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    n_chk++;
    if (dout_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL flush_empty got valid=%b level=%0d exp 0/0", dout_valid, level);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [2:0] exp_lvl;
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) q.push_back(mkw(16'(1 + 8*k), 8, 1'b0));
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      if (i % 8 == 0) begin
        exp_lvl = (i / 8 > 4) ? 3'd4 : 3'(i / 8);
        n_chk++;
        if (level !== exp_lvl) $display("FAIL ovf_level got %0d exp %0d", level, exp_lvl);
        else n_pass++;
      end
    end
    n_chk++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow);
    else n_pass++;
    dout_ready = 1'b1;
    repeat (5) drive(1'b0, '0, 1'b0);
    n_chk++;
    if (level !== 3'd0 || overflow !== 1'b1 || q.size() != 0)
      $display("FAIL ovf_drain got level=%0d ovf=%b pending=%0d exp 0/1/0", level, overflow, q.size());
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    n_chk++;
    if (overflow !== 1'b0 || level !== 3'd0) $display("FAIL reset_clears got ovf=%b level=%0d", overflow, level);
    else n_pass++;
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) q.push_back(mkw(16'(16'h4000 + 8*k), 8, 1'b0));
    for (int i = 0; i < 39; i++) drive(1'b1, 16'(16'h4000 + i), 1'b0);
    n_chk++;
    if (level !== 3'd4) $display("FAIL full_level got %0d exp 4", level);
    else n_pass++;
    dout_ready = 1'b1;
    drive(1'b1, 16'h4000 + 16'd39, 1'b0);
    dout_ready = 1'b0;
    n_chk++;
    if (level !== 3'd4 || overflow !== 1'b0) $display("FAIL full_pushpop got level=%0d ovf=%b exp 4/0", level, overflow);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
    dout_ready = 1'b1;
    repeat (4) drive(1'b0, '0, 1'b0);
    n_chk++;
    if (level !== 3'd0 || q.size() != 0) $display("FAIL full_drain got level=%0d pending=%0d", level, q.size());
    else n_pass++;
  endtask

  task automatic test_flush_with_din();
    exp_t e;
    dout_ready = 1'b1;
    e.data = {80'h0, 16'h3F80, 16'h2222, 16'h1111};
    e.keep = 8'h07;
    e.last = 1'b1;
    q.push_back(e);
    q.push_back(mkw(16'h5000, 8, 1'b0));
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    drive(1'b1, 16'h3F80, 1'b1);
    n_chk++;
    if (dout_keep !== 8'h07 || dout[2*DW +: DW] !== 16'h3F80 || dout_last !== 1'b1)
      $display("FAIL flush_din got keep=%h lane2=%h last=%b exp 07/3f80/1", dout_keep, dout[2*DW +: DW], dout_last);
    else n_pass++;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'h5000 + i), 1'b0);
    n_chk++;
    if (dout_keep !== 8'hFF || dout[DW-1:0] !== 16'h5000 || dout_last !== 1'b0)
      $display("FAIL flush_din_next got keep=%h lane0=%h last=%b exp ff/5000/0", dout_keep, dout[DW-1:0], dout_last);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    dout_ready = 1'b0;
    for (int i = 0; i < 21; i++) drive(1'b1, 16'(16'h7000 + i), 1'b0);
    n_chk++;
    if (level !== 3'd2) $display("FAIL pre_reset_level got %0d exp 2", level);
    else n_pass++;
    do_reset();
    n_chk++;
    if (dout_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0)
      $display("FAIL mid_reset got valid=%b level=%0d ovf=%b exp 0/0/0", dout_valid, level, overflow);
    else n_pass++;
    dout_ready = 1'b1;
    e = mkw(16'h6000, 8, 1'b0);
    q.push_back(e);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'h6000 + i), 1'b0);
    n_chk++;
    if (level !== 3'd1 || dout !== e.data || dout_keep !== 8'hFF)
      $display("FAIL post_reset_word got level=%0d dout=%h keep=%h exp 1/%h/ff", level, dout, dout_keep, e.data);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    n_chk++;
    if (level !== 3'd0 || q.size() != 0) $display("FAIL post_reset_drain got level=%0d pending=%0d", level, q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_overflow();
    test_full_push_pop();
    test_flush_with_din();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
